matrix_sequencer: RTL

MATRIX_SEQUENCER -- requirements
Module: matrix_sequencer

---
 rtl/matrix_sequencer_pkg.sv | 21 ++
 rtl/matrix_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_sequencer_pkg.sv
// rtl/matrix_sequencer_pkg.sv - shared widths, lane counts and FSM encoding for the matrix sequencer
package matrix_sequencer_pkg;

  localparam int bitLength       = 32;
  localparam int inputPortCount  = 4;
  localparam int outputPortCount = 4;
  localparam int addressLength   = 8;
  localparam int timeoutCycles   = 64;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_MUL = 3'd2,
    S_ACCUM    = 3'd3,
    S_DRAIN    = 3'd4,
    S_SETTLE   = 3'd5,
    S_RESULT   = 3'd6,
    S_CLEAR    = 3'd7
  } seq_state_e;

endpackage

// File: rtl/matrix_sequencer.sv
// rtl/matrix_sequencer.sv - sequences dot-product beats through the multiplier/adder accelerator
module matrix_sequencer
  import matrix_sequencer_pkg::*;
#(
  parameter int IN_PORTS  = inputPortCount,
  parameter int OUT_PORTS = outputPortCount,
  parameter int BIT_LEN   = bitLength,
  parameter int ADDR_LEN  = addressLength,
  parameter int TIMEOUT   = timeoutCycles
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [IN_PORTS*BIT_LEN-1:0] job_mult,
  input  logic [IN_PORTS*BIT_LEN-1:0] job_mcand,
  input  logic [ADDR_LEN-1:0]         job_addr,
  input  logic                        job_direct,
  input  logic [OUT_PORTS-1:0]        job_add_mask,
  input  logic                        job_last,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [2*BIT_LEN-1:0]        res_data,
  output logic                        res_err,
  output logic [IN_PORTS-1:0]         mStart,
  output logic [IN_PORTS*BIT_LEN-1:0] multiplier_input,
  output logic [IN_PORTS*BIT_LEN-1:0] multiplicand_input,
  output logic [ADDR_LEN-1:0]         AddressSelect,
  output logic                        direct,
  output logic [OUT_PORTS-1:0]        Add,
  output logic                        finalAdd,
  output logic                        acc_clr,
  input  logic [IN_PORTS-1:0]         mReady,
  input  logic [2*BIT_LEN-1:0]        finalAccumulate
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(OUT_PORTS + 2);

  seq_state_e                  state_q, state_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [IN_PORTS*BIT_LEN-1:0] mult_q, mult_d, mcand_q, mcand_d;
  logic [ADDR_LEN-1:0]         addr_q, addr_d;
  logic                        direct_q, direct_d, last_q, last_d;
  logic [OUT_PORTS-1:0]        add_mask_q, add_mask_d, add_q, add_d;
  logic [IN_PORTS-1:0]         mstart_q, mstart_d;
  logic                        final_add_q, final_add_d, acc_clr_q, acc_clr_d;
  logic                        ready_q, ready_d, res_valid_q, res_valid_d, res_err_q, res_err_d;
  logic [2*BIT_LEN-1:0]        res_data_q, res_data_d;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      mult_q      <= '0;
      mcand_q     <= '0;
      addr_q      <= '0;
      direct_q    <= 1'b0;
      last_q      <= 1'b0;
      add_mask_q  <= '0;
      add_q       <= '0;
      mstart_q    <= '0;
      final_add_q <= 1'b0;
      acc_clr_q   <= 1'b0;
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      mult_q      <= mult_d;
      mcand_q     <= mcand_d;
      addr_q      <= addr_d;
      direct_q    <= direct_d;
      last_q      <= last_d;
      add_mask_q  <= add_mask_d;
      add_q       <= add_d;
      mstart_q    <= mstart_d;
      final_add_q <= final_add_d;
      acc_clr_q   <= acc_clr_d;
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    mult_d     = mult_q;
    mcand_d    = mcand_q;
    addr_d     = addr_q;
    direct_d   = direct_q;
    last_d     = last_q;
    add_mask_d = add_mask_q;
    res_err_d  = res_err_q;
    res_data_d = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (job_valid && ready_q) begin
          mult_d     = job_mult;
          mcand_d    = job_mcand;
          addr_d     = job_addr;
          direct_d   = job_direct;
          add_mask_d = job_add_mask;
          last_d     = job_last;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_MUL;
      end
      S_WAIT_MUL: begin
        if (&mReady) begin
          state_d = S_ACCUM;
        end else begin
          timer_d = timer_q + TW'(1);
          // A timed-out job still produces a result so the requester is never left waiting.
          if (timer_d == TW'(TIMEOUT)) begin
            res_err_d  = 1'b1;
            res_data_d = '0;
            state_d    = S_RESULT;
          end
        end
      end
      S_ACCUM: begin
        cnt_d   = '0;
        state_d = last_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (cnt_q == CW'(OUT_PORTS - 1)) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(1)) begin
          res_data_d = finalAccumulate;
          res_err_d  = 1'b0;
          state_d    = S_RESULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_err_d  = 1'b0;
          res_data_d = '0;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so each flop lines up with its state cycle.
    mstart_d    = {IN_PORTS{state_d == S_ISSUE}};
    add_d       = (state_d == S_ACCUM) ? add_mask_q : '0;
    final_add_d = (state_d == S_DRAIN);
    acc_clr_d   = (state_d == S_CLEAR);
    ready_d     = (state_d == S_IDLE);
    res_valid_d = (state_d == S_RESULT);
  end

  assign job_ready          = ready_q;
  assign res_valid          = res_valid_q;
  assign res_err            = res_err_q;
  assign res_data           = res_data_q;
  assign mStart             = mstart_q;
  assign multiplier_input   = mult_q;
  assign multiplicand_input = mcand_q;
  assign AddressSelect      = addr_q;
  assign direct             = direct_q;
  assign Add                = add_q;
  assign finalAdd           = final_add_q;
  assign acc_clr            = acc_clr_q;

endmodule
